async_noc_router: RTL and testbench
===================================

Name: async_noc_router

Overview:
- 5-port mesh NoC router node for the spiking-CNN accelerator.
- Ports: CW, CCW (X dimension), SN, NS (Y dimension) and local PE.
- Accepts 64-bit flits on any input and routes each by dimension-order (X then Y) using header hop counts.
- Round-robin arbitration when several inputs contend for one output; valid/ready handshake on every port.

Parameters:
- WIDTH, 64, flit width; header layout below fixed, payload = WIDTH-1:16
- HOP_W, 4, width of each hop-count field

Ports:
- clk  in  1  single clock; all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- D_in_data  in  WIDTH  flit into router, for each D in {cw,ccw,sn,ns,pe}
- D_in_valid  in  1  flit on D_in_data valid
- D_in_ready  out  1  router accepts flit this cycle
- D_out_data  out  WIDTH  flit leaving router on port D
- D_out_valid  out  1  D_out_data valid
- D_out_ready  in  1  downstream accepts flit

Behaviour:
- Flit format:
  - bit0 = type (0 = data, passed through)
  - [4:1] hx = X hops
  - [8:5] hy = Y hops
  - [9] dir_x (0 = CW, 1 = CCW)
  - [10] dir_y (1 = SN, 0 = NS)
  - [15:11] reserved, pass through
  - [63:16] payload, never modified
- Route decision per flit, any input incl. PE:
  - hx != 0: output cw if dir_x = 0, else ccw.
  - Else hy != 0: output sn if dir_y = 1, else ns.
  - Else (hx = hy = 0): output pe.
- Same-direction and reverse turns are legal (e.g. cw in -> cw out).
- Hop update on forward:
  - X output: hx decremented by 1.
  - Y output: hy decremented by 1.
  - PE output: header unchanged.
- Input stage, per input: 1-entry buffer.
  - D_in_ready = buffer empty, or buffer granted this cycle.
  - Transfer on valid && ready at clk edge.
- Output stage, per output: round-robin arbiter over the 5 input buffers requesting it, plus a 1-entry output register.
  - Grant only when the output register is empty, or is being drained (out_valid && out_ready) this cycle.
  - On grant: register loads the updated flit and sets out_valid next cycle; the source buffer empties.
- Arbiter priority:
  - Order CW, CCW, SN, NS, PE.
  - Pointer moves to the input after the last granted one.
  - After reset the pointer favours CW.
- Latency: flit accepted at edge N appears with out_valid high after edge N+1 when uncontended and output ready.
- Throughput: 1 flit/cycle/output sustained.
- Handshake rules:
  - out_data stable while out_valid && !out_ready; out_valid never drops without a transfer.
  - in_ready may depend combinationally on out_ready (through grant), never on in_valid.
- Blocking: a blocked head flit blocks only its own input, no head-of-line effect on other inputs. No flit dropped, duplicated or reordered per input->output pair.
- Reset (rst_n low, asynchronous):
  - all buffers empty; all out_valid = 0; out_data = 0; all arbiter pointers = CW
  - in_ready = 0 while in reset, 1 from first cycle after release
  - a flit in flight at reset is discarded

Decomposition:
- Shared package noc_pkg holds:
  - flit field constants (hx/hy/dir_x/dir_y bit positions, PAYLOAD_LSB = 16)
  - port enum {CW, CCW, SN, NS, PE}
  - route function (header -> output port)
  - header-update function
- Sub-module rr_arbiter5: 5-request round-robin, grant one-hot, advance on accept.
  - Instantiated once per output.
- Input buffers and output registers are inline.

Test Plan:
- Basic routing from cw_in:
  - hx=1, dir_x=0, payload AAAA_AAAA_AAAA -> cw_out, hx=0
  - hx=0, hy=1, dir_y=1, payload BBBB_BBBB_BBBB -> sn_out, hy=0
  - hx=0, hy=1, dir_y=0, payload CCCC_CCCC_CCCC -> ns_out
  - hx=hy=0, payload DDDD_DDDD_DDDD -> pe_out, header unchanged
- Full route matrix, payloads A/B/C/D as above:
  - ccw_in, sn_in, ns_in, pe_in each send one flit to every reachable output.
  - Per-output payload sequence: ccw_out receives A, C, C, B; sn_out receives B, B, A, D; ns_out receives C, C, A, C; pe_out receives D, D, D, D.
- Arbitration:
  - After reset, send in the same cycle cw_in 1111_1111_1111 (hx=1, dir_x=0, hy=1), sn_in 2222…, ns_in 3333…, pe_in 4444… (all hx=1, dir_x=0).
  - cw_out must emit 1111, 2222, 3333, 4444 in that order, one per cycle, with the cw payload hx=0, hy=1.
- Backpressure:
  - Hold cw_out_ready=0 for 5 cycles while sending 2 flits to cw_out.
  - out_data stays stable; the contending input's in_ready drops.
  - Both flits arrive intact once ready=1.
- Parallel independence: flits cw_in->sn_out and pe_in->pe_out… (distinct outputs) in the same cycle both appear after 2 edges.
- Reset mid-traffic:
  - Assert rst_n low with buffered flits.
  - All out_valid = 0 immediately; no stale flit emitted after release.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared definitions for the mesh NoC router node.
// Contents:
//   - header field positions of a flit
//   - output/input port enumeration (CW, CCW, SN, NS, PE)
//   - route(): dimension-order (X then Y) routing decision from a header
//   - update_hdr(): hop-count decrement applied when a flit is forwarded
package noc_pkg;

  localparam int NUM_PORTS   = 5;
  localparam int HOP_FIELD_W = 4;

  // Header layout (bits 15:0 of every flit)
  localparam int TYPE_BIT    = 0;
  localparam int HX_LSB      = 1;
  localparam int HY_LSB      = 5;
  localparam int DIR_X_BIT   = 9;
  localparam int DIR_Y_BIT   = 10;
  localparam int RSV_LSB     = 11;
  localparam int PAYLOAD_LSB = 16;
  localparam int HDR_W       = PAYLOAD_LSB;

  typedef enum logic [2:0] {
    CW  = 3'd0,
    CCW = 3'd1,
    SN  = 3'd2,
    NS  = 3'd3,
    PE  = 3'd4
  } port_e;

  // X hops are exhausted before Y hops are considered; a flit with no hops
  // left is delivered to the local PE.
  function automatic port_e route(input logic [HDR_W-1:0] hdr);
    logic [HOP_FIELD_W-1:0] hx;
    logic [HOP_FIELD_W-1:0] hy;
    hx = hdr[HX_LSB +: HOP_FIELD_W];
    hy = hdr[HY_LSB +: HOP_FIELD_W];
    if (hx != '0) begin
      route = hdr[DIR_X_BIT] ? CCW : CW;
    end else if (hy != '0) begin
      route = hdr[DIR_Y_BIT] ? SN : NS;
    end else begin
      route = PE;
    end
  endfunction

  // Consumes one hop in the dimension the flit leaves on; delivery to the
  // PE leaves the header untouched.
  function automatic logic [HDR_W-1:0] update_hdr(input logic [HDR_W-1:0] hdr,
                                                  input port_e            dst);
    logic [HDR_W-1:0] h;
    h = hdr;
    case (dst)
      CW, CCW: h[HX_LSB +: HOP_FIELD_W] = hdr[HX_LSB +: HOP_FIELD_W] - 1'b1;
      SN, NS:  h[HY_LSB +: HOP_FIELD_W] = hdr[HY_LSB +: HOP_FIELD_W] - 1'b1;
      default: h = hdr;
    endcase
    return h;
  endfunction

endpackage

// File: rtl/async_noc_router_rr_arbiter5.sv
// 5-request round-robin arbiter, one instance per router output.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   req[4:0]   : requesting input buffers (CW, CCW, SN, NS, PE order)
//   en         : output register can take a flit this cycle
//   grant[4:0] : one-hot grant (all zero when en is low or nothing requests)
// The search starts at the pointer; after a grant the pointer moves to the
// input following the granted one so that input has lowest priority next.
module rr_arbiter5
  import noc_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] req,
  input  logic                 en,
  output logic [NUM_PORTS-1:0] grant
);

  logic [2:0] ptr;
  logic [2:0] ptr_nxt;
  logic [2:0] idx;
  logic [3:0] sum;
  logic       found;

  always_comb begin
    grant   = '0;
    ptr_nxt = ptr;
    found   = 1'b0;
    idx     = 3'd0;
    sum     = 4'd0;
    if (en) begin
      for (int k = 0; k < NUM_PORTS; k++) begin
        sum = {1'b0, ptr} + 4'(k);
        idx = (sum >= 4'd5) ? 3'(sum - 4'd5) : sum[2:0];
        if (!found && req[idx]) begin
          found      = 1'b1;
          grant[idx] = 1'b1;
          ptr_nxt    = (idx == 3'd4) ? 3'd0 : idx + 3'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= 3'(CW);
    end else begin
      ptr <= ptr_nxt;
    end
  end

endmodule

// File: rtl/async_noc_router.sv
// 5-port mesh NoC router node (CW, CCW, SN, NS, PE).
// Every input has a 1-entry buffer; every output has a round-robin arbiter
// over the buffers and a 1-entry output register. Routing is dimension
// order (X then Y) from the hop counts in the flit header, which is updated
// as the flit leaves. Payload and reserved bits pass through unchanged.
// Ports (D in {cw, ccw, sn, ns, pe}):
//   clk, rst_n      : clock, asynchronous active-low reset
//   D_in_data/valid : incoming flit and its valid
//   D_in_ready      : router accepts the incoming flit this cycle
//   D_out_data/valid: outgoing flit and its valid
//   D_out_ready     : downstream accepts the outgoing flit
module async_noc_router
  import noc_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int HOP_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] cw_in_data,
  input  logic             cw_in_valid,
  output logic             cw_in_ready,
  input  logic [WIDTH-1:0] ccw_in_data,
  input  logic             ccw_in_valid,
  output logic             ccw_in_ready,
  input  logic [WIDTH-1:0] sn_in_data,
  input  logic             sn_in_valid,
  output logic             sn_in_ready,
  input  logic [WIDTH-1:0] ns_in_data,
  input  logic             ns_in_valid,
  output logic             ns_in_ready,
  input  logic [WIDTH-1:0] pe_in_data,
  input  logic             pe_in_valid,
  output logic             pe_in_ready,
  output logic [WIDTH-1:0] cw_out_data,
  output logic             cw_out_valid,
  input  logic             cw_out_ready,
  output logic [WIDTH-1:0] ccw_out_data,
  output logic             ccw_out_valid,
  input  logic             ccw_out_ready,
  output logic [WIDTH-1:0] sn_out_data,
  output logic             sn_out_valid,
  input  logic             sn_out_ready,
  output logic [WIDTH-1:0] ns_out_data,
  output logic             ns_out_valid,
  input  logic             ns_out_ready,
  output logic [WIDTH-1:0] pe_out_data,
  output logic             pe_out_valid,
  input  logic             pe_out_ready
);

  // The header layout is fixed; other hop widths are not supported.
  if (HOP_W != HOP_FIELD_W || WIDTH <= PAYLOAD_LSB) begin : g_bad_cfg
    $error("async_noc_router: unsupported WIDTH/HOP_W");
  end

  logic [WIDTH-1:0]     in_data   [NUM_PORTS];
  logic [NUM_PORTS-1:0] in_valid;
  logic [NUM_PORTS-1:0] in_ready;
  logic [NUM_PORTS-1:0] out_ready;

  assign in_data[0] = cw_in_data;
  assign in_data[1] = ccw_in_data;
  assign in_data[2] = sn_in_data;
  assign in_data[3] = ns_in_data;
  assign in_data[4] = pe_in_data;
  assign in_valid   = {pe_in_valid, ns_in_valid, sn_in_valid, ccw_in_valid, cw_in_valid};
  assign out_ready  = {pe_out_ready, ns_out_ready, sn_out_ready, ccw_out_ready, cw_out_ready};

  assign cw_in_ready  = in_ready[0];
  assign ccw_in_ready = in_ready[1];
  assign sn_in_ready  = in_ready[2];
  assign ns_in_ready  = in_ready[3];
  assign pe_in_ready  = in_ready[4];

  logic [WIDTH-1:0]     flit_p0 [NUM_PORTS];
  logic [NUM_PORTS-1:0] vld_p0;
  port_e                dst_p0  [NUM_PORTS];
  logic [NUM_PORTS-1:0] taken;
  logic [NUM_PORTS-1:0] req     [NUM_PORTS];
  logic [NUM_PORTS-1:0] grant   [NUM_PORTS];
  logic [NUM_PORTS-1:0] out_free;
  logic [WIDTH-1:0]     sel     [NUM_PORTS];
  logic [WIDTH-1:0]     nxt     [NUM_PORTS];
  logic [WIDTH-1:0]     flit_p1 [NUM_PORTS];
  logic [NUM_PORTS-1:0] vld_p1;

  // ---- p0: input buffers ----
  // A buffer can refill in the same cycle its flit is granted onward, so
  // ready depends on out_ready (through grant) but never on in_valid.
  assign in_ready = rst_n ? (~vld_p0 | taken) : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p0 <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (in_valid[i] && in_ready[i]) begin
          vld_p0[i] <= 1'b1;
        end else if (taken[i]) begin
          vld_p0[i] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (in_valid[i] && in_ready[i]) begin
        flit_p0[i] <= in_data[i];
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      dst_p0[i] = route(flit_p0[i][HDR_W-1:0]);
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      req[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        req[o][i] = vld_p0[i] && (dst_p0[i] == port_e'(o));
      end
    end
  end

  // Each buffer requests exactly one output, so at most one grant hits it.
  always_comb begin
    taken = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      taken = taken | grant[o];
    end
  end

  // ---- p1: arbitration and output registers ----
  assign out_free = ~vld_p1 | out_ready;

  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
    rr_arbiter5 u_arb (
      .clk   (clk),
      .rst_n (rst_n),
      .req   (req[o]),
      .en    (out_free[o]),
      .grant (grant[o])
    );
  end

  always_comb begin
    for (int o = 0; o < NUM_PORTS; o++) begin
      sel[o] = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (grant[o][i]) begin
          sel[o] = flit_p0[i];
        end
      end
      nxt[o] = {sel[o][WIDTH-1:HDR_W], update_hdr(sel[o][HDR_W-1:0], port_e'(o))};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= '0;
      for (int o = 0; o < NUM_PORTS; o++) begin
        flit_p1[o] <= '0;
      end
    end else begin
      for (int o = 0; o < NUM_PORTS; o++) begin
        if (|grant[o]) begin
          vld_p1[o]  <= 1'b1;
          flit_p1[o] <= nxt[o];
        end else if (out_ready[o]) begin
          vld_p1[o] <= 1'b0;
        end
      end
    end
  end

  assign cw_out_data   = flit_p1[0];
  assign ccw_out_data  = flit_p1[1];
  assign sn_out_data   = flit_p1[2];
  assign ns_out_data   = flit_p1[3];
  assign pe_out_data   = flit_p1[4];
  assign cw_out_valid  = vld_p1[0];
  assign ccw_out_valid = vld_p1[1];
  assign sn_out_valid  = vld_p1[2];
  assign ns_out_valid  = vld_p1[3];
  assign pe_out_valid  = vld_p1[4];

endmodule

// File: tb/tb_async_noc_router.sv
// Directed testbench for async_noc_router. Port index: 0 cw, 1 ccw, 2 sn, 3 ns, 4 pe.
module tb_async_noc_router;

  localparam logic [47:0] PA = 48'hAAAA_AAAA_AAAA;
  localparam logic [47:0] PB = 48'hBBBB_BBBB_BBBB;
  localparam logic [47:0] PC = 48'hCCCC_CCCC_CCCC;
  localparam logic [47:0] PD = 48'hDDDD_DDDD_DDDD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] in_data  [5];
  logic [63:0] out_data [5];
  logic [4:0]  in_valid = '0;
  logic [4:0]  in_ready;
  logic [4:0]  out_valid;
  logic [4:0]  out_ready = '1;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int          port;
    logic [63:0] data;
    int          cyc;
  } ev_t;
  ev_t log_q[$];

  logic [63:0] vec [5];
  logic [15:0] hin [5];
  logic [15:0] hex [5];
  logic [47:0] pay [5][5];
  logic [47:0] seq [5][4];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  async_noc_router dut (
    .clk(clk), .rst_n(rst_n),
    .cw_in_data(in_data[0]),  .cw_in_valid(in_valid[0]),  .cw_in_ready(in_ready[0]),
    .ccw_in_data(in_data[1]), .ccw_in_valid(in_valid[1]), .ccw_in_ready(in_ready[1]),
    .sn_in_data(in_data[2]),  .sn_in_valid(in_valid[2]),  .sn_in_ready(in_ready[2]),
    .ns_in_data(in_data[3]),  .ns_in_valid(in_valid[3]),  .ns_in_ready(in_ready[3]),
    .pe_in_data(in_data[4]),  .pe_in_valid(in_valid[4]),  .pe_in_ready(in_ready[4]),
    .cw_out_data(out_data[0]),  .cw_out_valid(out_valid[0]),  .cw_out_ready(out_ready[0]),
    .ccw_out_data(out_data[1]), .ccw_out_valid(out_valid[1]), .ccw_out_ready(out_ready[1]),
    .sn_out_data(out_data[2]),  .sn_out_valid(out_valid[2]),  .sn_out_ready(out_ready[2]),
    .ns_out_data(out_data[3]),  .ns_out_valid(out_valid[3]),  .ns_out_ready(out_ready[3]),
    .pe_out_data(out_data[4]),  .pe_out_valid(out_valid[4]),  .pe_out_ready(out_ready[4])
  );

  // Record every output transfer mid-cycle; it completes at the next rising edge.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int o = 0; o < 5; o++) begin
        if (out_valid[o] && out_ready[o]) log_q.push_back('{o, out_data[o], cyc});
      end
    end
  end

  function automatic logic [15:0] mkh(input int hx, input int hy, input int dx,
                                      input int dy, input int rsv);
    logic [31:0] a, b, c, d, e;
    a = hx; b = hy; c = dx; d = dy; e = rsv;
    return {e[4:0], d[0], c[0], b[3:0], a[3:0], 1'b0};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic expect_out(input int port, input logic [63:0] exp, input string tag,
                            output int t);
    int idx;
    idx = -1;
    t = -1;
    for (int k = 0; k < log_q.size(); k++) begin
      if (idx < 0 && log_q[k].port == port) idx = k;
    end
    check({tag, "_present"}, 64'(idx >= 0), 64'd1);
    if (idx >= 0) begin
      check(tag, log_q[idx].data, exp);
      t = log_q[idx].cyc;
      log_q.delete(idx);
    end
  endtask

  // Present vec[i] on every input in mask until each is accepted (bounded).
  task automatic send_set(input logic [4:0] mask);
    logic [4:0] pend;
    logic [4:0] acc;
    int n;
    pend = mask;
    n = 0;
    for (int i = 0; i < 5; i++) begin
      if (mask[i]) begin
        in_data[i]  = vec[i];
        in_valid[i] = 1'b1;
      end
    end
    while (pend != 0 && n < 50) begin
      @(negedge clk);
      acc = pend & in_ready;
      @(posedge clk);
      #1;
      for (int i = 0; i < 5; i++) begin
        if (acc[i]) in_valid[i] = 1'b0;
      end
      pend = pend & ~acc;
      n++;
    end
    in_valid = in_valid & ~mask;
    check("send_accepted", 64'(pend), 64'd0);
  endtask

  task automatic do_reset();
    in_valid = '0;
    out_ready = '1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    log_q.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t1, t2, t3, t4;
    for (int i = 0; i < 5; i++) in_data[i] = '0;

    // ---------------- reset state ----------------
    #12;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    for (int o = 0; o < 5; o++) check($sformatf("rst_out_data%0d", o), out_data[o], 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rel_in_ready", 64'(in_ready), 64'h1f);

    // ---------------- basic routing from cw_in ----------------
    do_reset();
    vec[0] = {PA, mkh(1, 0, 0, 0, 0)}; send_set(5'b00001);
    vec[0] = {PB, mkh(0, 1, 0, 1, 0)}; send_set(5'b00001);
    vec[0] = {PC, mkh(0, 1, 0, 0, 0)}; send_set(5'b00001);
    vec[0] = {PD, mkh(0, 0, 0, 0, 0)}; send_set(5'b00001);
    wait_cycles(4);
    expect_out(0, {PA, mkh(0, 0, 0, 0, 0)}, "basic_cw", t1);
    expect_out(2, {PB, mkh(0, 0, 0, 1, 0)}, "basic_sn", t1);
    expect_out(3, {PC, mkh(0, 0, 0, 0, 0)}, "basic_ns", t1);
    expect_out(4, {PD, mkh(0, 0, 0, 0, 0)}, "basic_pe", t1);

    // ---------------- full route matrix ----------------
    hin[0] = mkh(2, 0, 0, 0, 5'h0a); hex[0] = mkh(1, 0, 0, 0, 5'h0a);
    hin[1] = mkh(1, 3, 1, 1, 0);     hex[1] = mkh(0, 3, 1, 1, 0);
    hin[2] = mkh(0, 2, 1, 1, 5'h11); hex[2] = mkh(0, 1, 1, 1, 5'h11);
    hin[3] = mkh(0, 1, 1, 0, 0);     hex[3] = mkh(0, 0, 1, 0, 0);
    hin[4] = mkh(0, 0, 0, 1, 5'h1f); hex[4] = mkh(0, 0, 0, 1, 5'h1f);
    pay[1] = '{PA, PA, PB, PC, PD};
    pay[2] = '{PB, PC, PB, PC, PD};
    pay[3] = '{PC, PC, PA, PA, PD};
    pay[4] = '{PD, PB, PD, PC, PD};
    seq[0] = '{PA, PB, PC, PD};
    seq[1] = '{PA, PC, PC, PB};
    seq[2] = '{PB, PB, PA, PD};
    seq[3] = '{PC, PC, PA, PC};
    seq[4] = '{PD, PD, PD, PD};
    do_reset();
    for (int i = 1; i < 5; i++) begin
      for (int o = 0; o < 5; o++) begin
        vec[i] = {pay[i][o], hin[o]};
        send_set(5'(1 << i));
      end
    end
    wait_cycles(6);
    for (int o = 0; o < 5; o++) begin
      for (int k = 0; k < 4; k++) begin
        expect_out(o, {seq[o][k], hex[o]}, $sformatf("mtx_o%0d_k%0d", o, k), t1);
      end
    end

    // ---------------- arbitration ----------------
    do_reset();
    vec[0] = {48'h1111_1111_1111, mkh(1, 1, 0, 0, 0)};
    vec[2] = {48'h2222_2222_2222, mkh(1, 0, 0, 0, 0)};
    vec[3] = {48'h3333_3333_3333, mkh(1, 0, 0, 0, 0)};
    vec[4] = {48'h4444_4444_4444, mkh(1, 0, 0, 0, 0)};
    send_set(5'b11101);
    wait_cycles(8);
    expect_out(0, {48'h1111_1111_1111, mkh(0, 1, 0, 0, 0)}, "arb_1", t1);
    expect_out(0, {48'h2222_2222_2222, mkh(0, 0, 0, 0, 0)}, "arb_2", t2);
    expect_out(0, {48'h3333_3333_3333, mkh(0, 0, 0, 0, 0)}, "arb_3", t3);
    expect_out(0, {48'h4444_4444_4444, mkh(0, 0, 0, 0, 0)}, "arb_4", t4);
    check("arb_gap12", 64'(t2 - t1), 64'd1);
    check("arb_gap23", 64'(t3 - t2), 64'd1);
    check("arb_gap34", 64'(t4 - t3), 64'd1);

    // ---------------- backpressure ----------------
    do_reset();
    out_ready[0] = 1'b0;
    vec[0] = {48'h5555_5555_5555, mkh(1, 0, 0, 0, 0)};
    vec[2] = {48'h6666_6666_6666, mkh(2, 0, 0, 0, 0)};
    send_set(5'b00101);
    wait_cycles(1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_valid", 64'(out_valid[0]), 64'd1);
      check("bp_data", out_data[0], {48'h5555_5555_5555, mkh(0, 0, 0, 0, 0)});
      check("bp_sn_ready", 64'(in_ready[2]), 64'd0);
    end
    @(posedge clk);
    #1 out_ready[0] = 1'b1;
    wait_cycles(4);
    expect_out(0, {48'h5555_5555_5555, mkh(0, 0, 0, 0, 0)}, "bp_first", t1);
    expect_out(0, {48'h6666_6666_6666, mkh(1, 0, 0, 0, 0)}, "bp_second", t2);
    check("bp_gap", 64'(t2 - t1), 64'd1);

    // ---------------- parallel independence / latency ----------------
    do_reset();
    in_data[0] = {48'hEEEE_EEEE_EEEE, mkh(0, 1, 0, 1, 0)};
    in_data[4] = {48'hFFFF_FFFF_FFFF, mkh(0, 0, 0, 0, 5'h1f)};
    in_valid = 5'b10001;
    @(negedge clk);
    check("par_ready", 64'({in_ready[4], in_ready[0]}), 64'd3);
    @(posedge clk);
    #1 in_valid = '0;
    @(negedge clk);
    check("par_early", 64'({out_valid[4], out_valid[2]}), 64'd0);
    @(negedge clk);
    check("par_valid", 64'({out_valid[4], out_valid[2]}), 64'd3);
    check("par_sn_data", out_data[2], {48'hEEEE_EEEE_EEEE, mkh(0, 0, 0, 1, 0)});
    check("par_pe_data", out_data[4], {48'hFFFF_FFFF_FFFF, mkh(0, 0, 0, 0, 5'h1f)});

    // ---------------- reset mid-traffic ----------------
    do_reset();
    out_ready = '0;
    vec[0] = {PA, mkh(1, 0, 0, 0, 0)}; send_set(5'b00001);
    vec[0] = {PB, mkh(1, 0, 0, 0, 0)}; send_set(5'b00001);
    vec[4] = {PD, mkh(0, 0, 0, 0, 0)}; send_set(5'b10000);
    wait_cycles(1);
    @(negedge clk);
    check("mid_pre_valid", 64'({out_valid[4], out_valid[0]}), 64'd3);
    #2 rst_n = 1'b0;
    #1;
    check("mid_out_valid", 64'(out_valid), 64'd0);
    check("mid_in_ready", 64'(in_ready), 64'd0);
    check("mid_cw_data", out_data[0], 64'd0);
    check("mid_pe_data", out_data[4], 64'd0);
    log_q.delete();
    out_ready = '1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rel_ready", 64'(in_ready), 64'h1f);
    wait_cycles(5);
    check("mid_no_stale", 64'(log_q.size()), 64'd0);
    check("mid_valid_after", 64'(out_valid), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
